alu_control: RTL and testbench



---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_decode.sv | 45 ++++
 rtl/alu_control.sv | 44 ++++
 tb/tb_alu_control.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared encodings for the RV32I ALU path.
//   - ALU_*   : 4-bit ALU operation select, produced by alu_control and
//               consumed by the ALU.
//   - ALUOP_* : 2-bit operation class, produced by the main decoder and
//               consumed by alu_control.
//   - F3_*    : funct3 values for the R/I arithmetic instruction groups.
//   Selects 1011..1111 are reserved and never produced.
package alu_pkg;

  // ALU operation select encodings
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;

  // Operation classes from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // load/store address
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // decode funct fields
  localparam logic [1:0] ALUOP_LUI   = 2'b11;  // LUI pass-through

  // funct3 groups for R/I arithmetic
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SHR    = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_decode.sv
// alu_decode
//   Purely combinational decode of (operation class, funct3, funct7[5])
//   into the next ALU operation select. Holds no state.
//   Ports:
//     aluOp_i    [1:0]  operation class from the main decoder
//     funct3_i   [2:0]  instruction bits [14:12]
//     funct7_5_i        instruction bit 30
//     aluCtrl_o  [3:0]  decoded ALU operation select
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluOp_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] aluCtrl_o
);

  // ADD is assigned first so every path, including unknown inputs that
  // fall into the default branches, yields a defined ADD and no latch.
  // funct7[5] only distinguishes ADD/SUB and SRL/SRA; it is ignored for
  // every other funct3 and for the fixed classes.
  always_comb begin
    aluCtrl_o = ALU_ADD;
    case (aluOp_i)
      ALUOP_ADD: aluCtrl_o = ALU_ADD;
      ALUOP_SUB: aluCtrl_o = ALU_SUB;
      ALUOP_LUI: aluCtrl_o = ALU_LUI;
      ALUOP_FUNCT: begin
        case (funct3_i)
          F3_ADDSUB: aluCtrl_o = funct7_5_i ? ALU_SUB : ALU_ADD;
          F3_SLL:    aluCtrl_o = ALU_SLL;
          F3_SLT:    aluCtrl_o = ALU_SLT;
          F3_SLTU:   aluCtrl_o = ALU_SLTU;
          F3_XOR:    aluCtrl_o = ALU_XOR;
          F3_SHR:    aluCtrl_o = funct7_5_i ? ALU_SRA : ALU_SRL;
          F3_OR:     aluCtrl_o = ALU_OR;
          F3_AND:    aluCtrl_o = ALU_AND;
          default:   aluCtrl_o = ALU_ADD;
        endcase
      end
      default: aluCtrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// alu_control
//   Registered ALU control: decodes the main decoder's operation class plus
//   funct3/funct7[5] and presents the ALU operation select one clock later.
//   Ports:
//     clk       system clock, rising edge
//     rst_n     asynchronous active-low reset; forces ALUCtrl to ADD
//     ALUOp     [1:0] operation class
//     funct3    [2:0] instruction bits [14:12]
//     funct7_5  instruction bit 30
//     ALUCtrl   [3:0] registered ALU operation select
module alu_control
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] ALUCtrl
);

  logic [3:0] aluCtrl_d;
  logic [3:0] aluCtrl_q;

  alu_decode u_decode (
    .aluOp_i    (ALUOp),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .aluCtrl_o  (aluCtrl_d)
  );

  // Single output register. There is no enable: a fresh decode is captured
  // on every edge, and reset discards whatever was pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluCtrl_q <= ALU_ADD;
    end else begin
      aluCtrl_q <= aluCtrl_d;
    end
  end

  assign ALUCtrl = aluCtrl_q;

endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control
//   Self-checking bench for alu_control: directed cases with literal
//   expectations, then randomized inputs and reset pulses checked every
//   cycle against a table-driven reference model.
module tb_alu_control;

  logic       clk;
  logic       rst_n;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [3:0] ALUCtrl;

  int checks;
  int errors;

  logic [3:0] expCtrl;

  // Base select for each funct3 with funct7[5]=0; the alternate form
  // (SUB, SRA) is the next encoding up.
  logic [3:0] baseTab [0:7] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  alu_control dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ALUOp    (ALUOp),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .ALUCtrl  (ALUCtrl)
  );

  // 10-time-unit clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode straight from the instruction-class rules
  function automatic logic [3:0] refDecode(input logic [1:0] op,
                                           input logic [2:0] f3,
                                           input logic       f7);
    logic [3:0] r;
    if (op == 2'd0)      r = 4'd0;
    else if (op == 2'd1) r = 4'd1;
    else if (op == 2'd3) r = 4'd10;
    else begin
      r = baseTab[f3];
      if (f7 && (f3 == 3'd0 || f3 == 3'd5)) r = r + 4'd1;
    end
    return r;
  endfunction

  // Expected register contents: captured at each edge, cleared by reset
  always @(posedge clk) begin
    if (rst_n) expCtrl = refDecode(ALUOp, funct3, funct7_5);
    else       expCtrl = 4'd0;
  end

  always @(negedge rst_n) expCtrl = 4'd0;

  // Per-cycle comparison on the falling edge, away from the capture edge
  always @(negedge clk) begin
    checks++;
    if (ALUCtrl !== expCtrl) begin
      errors++;
      $display("[TB] FAIL cycle_model t=%0t got=%b expected=%b", $time, ALUCtrl, expCtrl);
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] want);
    checks++;
    if (ALUCtrl !== want) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got=%b expected=%b", name, $time, ALUCtrl, want);
    end
  endtask

  // Drive inputs, let one rising edge pass, then check at edge+2
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3,
                               input logic f7, input string name,
                               input logic [3:0] want);
    ALUOp    = op;
    funct3   = f3;
    funct7_5 = f7;
    @(posedge clk);
    #2;
    checkOutput(name, want);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    expCtrl  = 4'd0;
    rst_n    = 1'b1;
    ALUOp    = 2'b11;
    funct3   = 3'b000;
    funct7_5 = 1'b0;

    // Reset with no clock edge yet, then held across an edge
    #1 rst_n = 1'b0;
    #1 checkOutput("reset_no_clock", 4'b0000);
    @(posedge clk);
    #2 checkOutput("reset_dominates_edge", 4'b0000);
    #1 rst_n = 1'b1;
    applyStimulus(2'b11, 3'b000, 1'b0, "release_first_edge_lui", 4'b1010);

    // Fixed classes ignore funct fields
    applyStimulus(2'b00, 3'b101, 1'b1, "aluop00_add", 4'b0000);
    applyStimulus(2'b01, 3'b010, 1'b1, "aluop01_sub", 4'b0001);
    applyStimulus(2'b11, 3'b000, 1'b0, "aluop11_lui", 4'b1010);

    // funct7[5]-sensitive groups
    applyStimulus(2'b10, 3'b000, 1'b0, "f3_000_add", 4'b0000);
    applyStimulus(2'b10, 3'b000, 1'b1, "f3_000_sub", 4'b0001);
    applyStimulus(2'b10, 3'b101, 1'b0, "f3_101_srl", 4'b0110);
    applyStimulus(2'b10, 3'b101, 1'b1, "f3_101_sra", 4'b0111);

    // funct7[5]-insensitive groups, both polarities
    for (int f = 0; f < 2; f++) begin
      applyStimulus(2'b10, 3'b001, f[0], "f3_001_sll",  4'b0010);
      applyStimulus(2'b10, 3'b010, f[0], "f3_010_slt",  4'b0011);
      applyStimulus(2'b10, 3'b011, f[0], "f3_011_sltu", 4'b0100);
      applyStimulus(2'b10, 3'b100, f[0], "f3_100_xor",  4'b0101);
      applyStimulus(2'b10, 3'b110, f[0], "f3_110_or",   4'b1000);
      applyStimulus(2'b10, 3'b111, f[0], "f3_111_and",  4'b1001);
    end

    // Mid-cycle input change must not show until the next edge
    applyStimulus(2'b10, 3'b100, 1'b0, "pre_midcycle_xor", 4'b0101);
    #5;
    ALUOp  = 2'b10;
    funct3 = 3'b110;
    #1 checkOutput("midcycle_hold", 4'b0101);
    @(posedge clk);
    #2 checkOutput("midcycle_update", 4'b1000);

    // Mid-stream reset pulse between edges
    applyStimulus(2'b11, 3'b111, 1'b1, "pre_reset_lui", 4'b1010);
    #1 rst_n = 1'b0;
    #1 checkOutput("midstream_reset_immediate", 4'b0000);
    rst_n    = 1'b1;
    ALUOp    = 2'b10;
    funct3   = 3'b001;
    funct7_5 = 1'b1;
    @(posedge clk);
    #2 checkOutput("after_release_sll", 4'b0010);

    // Randomized traffic with occasional reset pulses and mid-cycle changes
    repeat (400) begin
      ALUOp    = 2'($urandom_range(3));
      funct3   = 3'($urandom_range(7));
      funct7_5 = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) begin
        #1 rst_n = 1'b0;
        #1 checkOutput("rand_async_reset", 4'b0000);
        rst_n = 1'b1;
      end
      if ($urandom_range(7) == 0) begin
        #4;
        ALUOp    = 2'($urandom_range(3));
        funct3   = 3'($urandom_range(7));
        funct7_5 = 1'($urandom_range(1));
      end
      @(posedge clk);
      #2;
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
